// File: rtl/pwm_symbol_decoder.sv
// PWM symbol decoder: hysteresis slicer, glitch-filtered pulse-width measure, width->symbol quantiser.
// Latency: symbol_valid two enabled cycles after the first sub-threshold sample; enable=0 freezes all state.
// Optional PWM_DEC_PERIOD_EN adds a rising-edge period measurement (period / period_valid).
module pwm_symbol_decoder #(
    parameter int DATA_W      = 16,
    parameter int CNT_W       = 12,
    parameter int SYM_W       = 8,
    parameter int NUM_SYMBOLS = 4,
    parameter int MIN_WIDTH   = 4,
    parameter int STEP_SHIFT  = 3,
    parameter int MAX_WIDTH   = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] ref_in,
    input  logic [DATA_W-2:0] hyst,
    input  logic [DATA_W-1:0] data_in,
    output logic              level,
    output logic [SYM_W-1:0]  symbol,
    output logic              symbol_valid,
    output logic              timeout_err
`ifdef PWM_DEC_PERIOD_EN
    ,
    output logic [CNT_W-1:0]  period,
    output logic              period_valid
`endif
);

    localparam int EXT_W = DATA_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] SYM_MAX_C = CNT_W'(NUM_SYMBOLS - 1);

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        MEASURE   = 2'd2,
        OVERRUN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SYM_W-1:0]   symbol_q, symbol_d;
    logic               symbol_valid_q, symbol_valid_d;
    logic               timeout_err_q, timeout_err_d;

    logic signed [EXT_W-1:0] data_x, ref_x, hyst_x, hi_x, lo_x;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   step_v;
    logic [CNT_W-1:0]   step_clamped;

    // Two guard bits keep ref+hyst and ref-hyst exact at the input extremes.
    assign data_x = {{2{data_in[DATA_W-1]}}, data_in};
    assign ref_x  = {{2{ref_in[DATA_W-1]}}, ref_in};
    assign hyst_x = {3'b000, hyst};
    assign hi_x   = ref_x + hyst_x;
    assign lo_x   = ref_x - hyst_x;

    assign cnt_inc      = cnt_q + 1'b1;
    assign step_v       = (cnt_q - MIN_C) >> STEP_SHIFT;
    assign step_clamped = (step_v > SYM_MAX_C) ? SYM_MAX_C : step_v;

    always_comb begin
        level_d        = level_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        symbol_d       = symbol_q;
        symbol_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
        if (enable) begin
            if (!level_q && (data_x > hi_x)) begin
                level_d = 1'b1;
            end else if (level_q && (data_x < lo_x)) begin
                level_d = 1'b0;
            end

            case (state_q)
                // Leave only once the line is low and staying low, so a pulse
                // already in progress when reset releases is never measured.
                WAIT_LOW: begin
                    if (!level_q && !level_d) begin
                        state_d = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (level_q) begin
                        cnt_d   = CNT_W'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (level_q) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == MAX_C) begin
                                timeout_err_d = 1'b1;
                                state_d       = OVERRUN;
                            end
                        end
                    end else begin
                        state_d = WAIT_HIGH;
                        if (cnt_q >= MIN_C) begin
                            symbol_d       = SYM_W'(step_clamped);
                            symbol_valid_d = 1'b1;
                        end
                    end
                end
                OVERRUN: begin
                    if (!level_q) begin
                        state_d = WAIT_HIGH;
                    end
                end
                default: state_d = WAIT_LOW;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= WAIT_LOW;
            level_q        <= 1'b0;
            cnt_q          <= '0;
            symbol_q       <= '0;
            symbol_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            cnt_q          <= cnt_d;
            symbol_q       <= symbol_d;
            symbol_valid_q <= symbol_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign level        = level_q;
    assign symbol       = symbol_q;
    assign symbol_valid = symbol_valid_q;
    assign timeout_err  = timeout_err_q;

`ifdef PWM_DEC_PERIOD_EN
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             per_seen_q, per_seen_d;
    logic             period_valid_q, period_valid_d;
    logic             pulse_start;

    // Same event that loads cnt=1: the start of every measured, glitch or overrun pulse.
    assign pulse_start = (state_q == WAIT_HIGH) && level_q;

    always_comb begin
        per_cnt_d      = per_cnt_q;
        period_d       = period_q;
        per_seen_d     = per_seen_q;
        period_valid_d = 1'b0;
        if (enable) begin
            if (pulse_start) begin
                if (per_seen_q) begin
                    period_d       = per_cnt_q;
                    period_valid_d = 1'b1;
                end
                per_cnt_d  = CNT_W'(1);
                per_seen_d = 1'b1;
            end else if (per_cnt_q != CNT_MAX) begin
                per_cnt_d = per_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            per_cnt_q      <= '0;
            period_q       <= '0;
            per_seen_q     <= 1'b0;
            period_valid_q <= 1'b0;
        end else begin
            per_cnt_q      <= per_cnt_d;
            period_q       <= period_d;
            per_seen_q     <= per_seen_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
`endif

endmodule

// File: tb/tb_pwm_symbol_decoder.sv
// Self-checking bench for pwm_symbol_decoder: slicer vector table, directed pulse sequences,
// and a randomized run scored against a pulse-level reference model.
module tb_pwm_symbol_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] ref_in;
    logic [14:0] hyst;
    logic [15:0] data_in;
    logic        level;
    logic [7:0]  symbol;
    logic        symbol_valid;
    logic        timeout_err;
`ifdef PWM_DEC_PERIOD_EN
    logic [11:0] period;
    logic        period_valid;
`endif

    pwm_symbol_decoder dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .ref_in       (ref_in),
        .hyst         (hyst),
        .data_in      (data_in),
        .level        (level),
        .symbol       (symbol),
        .symbol_valid (symbol_valid),
        .timeout_err  (timeout_err)
`ifdef PWM_DEC_PERIOD_EN
        ,
        .period       (period),
        .period_valid (period_valid)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int sv_cnt, to_cnt, last_sym, pv_cnt, last_per;
    int dut_q[$];
    int exp_q[$];

    typedef struct {
        logic [15:0] ref_v;
        logic [14:0] hyst_v;
        logic [15:0] data_v;
        logic        exp_level;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        sv_cnt = 0; to_cnt = 0; last_sym = -1; pv_cnt = 0; last_per = -1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (symbol_valid) begin
            sv_cnt++;
            last_sym = int'(symbol);
            dut_q.push_back(int'(symbol));
        end
        if (timeout_err) begin
            to_cnt++;
            dut_q.push_back(-1);
        end
`ifdef PWM_DEC_PERIOD_EN
        if (period_valid) begin
            pv_cnt++;
            last_per = int'(period);
        end
`endif
    endtask

    task automatic run(input int n, input logic [15:0] d);
        data_in = d;
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Reference model state for the randomized run
    int m_level, m_width, m_first, m_discard;
    int r_ref, r_hyst;

    function automatic int sym_of(input int w);
        int s;
        s = (w - 4) / 8;
        return (s > 3) ? 3 : s;
    endfunction

    task automatic model_cycle(input int d, input logic en);
        int nl;
        if (en) begin
            nl = m_level;
            if (m_level == 0 && d > r_ref + r_hyst) nl = 1;
            if (m_level == 1 && d < r_ref - r_hyst) nl = 0;
            if (nl == 1 && m_level == 0) begin
                m_width   = 0;
                m_discard = m_first;
            end
            if (nl == 1) begin
                m_width++;
                if (m_width == 255 && !m_discard) exp_q.push_back(-1);
            end
            if (nl == 0 && m_level == 1 && !m_discard && m_width >= 4 && m_width < 255)
                exp_q.push_back(sym_of(m_width));
            m_level = nl;
            m_first = 0;
        end
    endtask

    initial begin
        int vld_at;
        reset   = 1'b1;
        enable  = 1'b1;
        ref_in  = 16'(65);
        hyst    = 15'(0);
        data_in = 16'(-345);
        clear_counts();
        repeat (3) step();
        check("reset_level", level, 0);
        check("reset_symbol", symbol, 0);
        check("reset_valid", symbol_valid, 0);
        check("reset_timeout", timeout_err, 0);
        reset = 1'b0;

        // Slicer vectors, applied in sequence (level state carries over)
        vecs[0]  = '{16'(65), 15'(5), 16'(62), 1'b0};
        vecs[1]  = '{16'(65), 15'(5), 16'(68), 1'b0};
        vecs[2]  = '{16'(65), 15'(5), 16'(70), 1'b0};
        vecs[3]  = '{16'(65), 15'(5), 16'(71), 1'b1};
        vecs[4]  = '{16'(65), 15'(5), 16'(62), 1'b1};
        vecs[5]  = '{16'(65), 15'(5), 16'(60), 1'b1};
        vecs[6]  = '{16'(65), 15'(5), 16'(59), 1'b0};
        vecs[7]  = '{16'(32767), 15'(32767), 16'(32767), 1'b0};
        vecs[8]  = '{16'(-32768), 15'(0), 16'(32767), 1'b1};
        vecs[9]  = '{16'(-32768), 15'(32767), 16'(-32768), 1'b1};
        vecs[10] = '{16'(32767), 15'(0), 16'(-32768), 1'b0};
        vecs[11] = '{16'(-32768), 15'(32767), 16'(32767), 1'b1};
        for (int i = 0; i < 12; i++) begin
            ref_in  = vecs[i].ref_v;
            hyst    = vecs[i].hyst_v;
            data_in = vecs[i].data_v;
            step();
            check($sformatf("slicer_vec%0d", i), level, vecs[i].exp_level);
        end

        ref_in = 16'(65);
        hyst   = 15'(0);
        data_in = 16'(-345);
        do_reset();

        // Normal pulse: 27 cycles -> symbol 2, strobe on the 2nd cycle after the fall
        run(10, 16'(-345));
        clear_counts();
        run(27, 16'(71));
        check("normal_level_high", level, 1);
        data_in = 16'(40);
        vld_at  = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (symbol_valid && vld_at == 0) vld_at = k;
        end
        check("normal_latency", vld_at, 2);
        check("normal_valid_cnt", sv_cnt, 1);
        check("normal_symbol", last_sym, 2);
        check("normal_timeout", to_cnt, 0);

        // Glitch then a 12-cycle pulse
        clear_counts();
        run(3, 16'(71));
        run(10, 16'(40));
        check("glitch_no_valid", sv_cnt, 0);
        run(12, 16'(71));
        run(5, 16'(40));
        check("after_glitch_valid", sv_cnt, 1);
        check("after_glitch_symbol", last_sym, 1);

        // Clamp and timeout boundaries
        clear_counts();
        run(60, 16'(71));
        run(5, 16'(40));
        check("clamp60_symbol", last_sym, 3);
        clear_counts();
        run(254, 16'(71));
        run(5, 16'(40));
        check("w254_valid", sv_cnt, 1);
        check("w254_symbol", last_sym, 3);
        check("w254_timeout", to_cnt, 0);
        clear_counts();
        run(255, 16'(71));
        run(5, 16'(40));
        check("w255_timeout", to_cnt, 1);
        check("w255_no_valid", sv_cnt, 0);
        clear_counts();
        run(300, 16'(71));
        run(5, 16'(40));
        check("w300_timeout", to_cnt, 1);
        run(20, 16'(71));
        run(5, 16'(40));
        check("after_overrun_symbol", last_sym, 2);

        // Enable freeze mid-pulse: 6 + 5 enabled cycles = width 11 -> symbol 0
        clear_counts();
        run(6, 16'(71));
        enable = 1'b0;
        repeat (5) begin
            data_in = 16'($urandom);
            step();
        end
        check("freeze_level_held", level, 1);
        check("freeze_no_strobes", sv_cnt + to_cnt, 0);
        enable = 1'b1;
        run(5, 16'(71));
        run(5, 16'(40));
        check("freeze_valid", sv_cnt, 1);
        check("freeze_symbol", last_sym, 0);

        // Asynchronous reset mid-pulse
        clear_counts();
        run(12, 16'(71));
        run(5, 16'(40));
        check("pre_reset_symbol", symbol, 1);
        run(10, 16'(71));
        #2 reset = 1'b1;
        #1;
        check("async_reset_level", level, 0);
        check("async_reset_symbol", symbol, 0);
        check("async_reset_valid", symbol_valid, 0);
        step();
        reset = 1'b0;
        clear_counts();
        run(30, 16'(71));
        run(10, 16'(40));
        check("partial_pulse_ignored", sv_cnt, 0);
        run(30, 16'(71));
        run(5, 16'(40));
        check("post_reset_valid", sv_cnt, 1);
        check("post_reset_symbol", last_sym, 3);

`ifdef PWM_DEC_PERIOD_EN
        do_reset();
        run(5, 16'(40));
        clear_counts();
        repeat (4) begin
            run(10, 16'(71));
            run(30, 16'(40));
        end
        check("period_valid_cnt", pv_cnt, 3);
        check("period_value", last_per, 40);
`endif

        // Randomized run against the pulse-level model
        r_ref  = $urandom_range(0, 2000) - 1000;
        r_hyst = $urandom_range(0, 50);
        ref_in = 16'(r_ref);
        hyst   = 15'(r_hyst);
        reset  = 1'b1;
        step();
        data_in = 16'(r_ref + r_hyst + 10);
        reset   = 1'b0;
        m_level = 0; m_width = 0; m_first = 1; m_discard = 0;
        dut_q.delete();
        exp_q.delete();
        for (int seg = 0; seg < 80; seg++) begin
            int len, r, d;
            logic en;
            if (seg % 2 == 0) begin
                r = $urandom_range(0, 9);
                if (r < 6)      len = $urandom_range(1, 40);
                else if (r < 8) len = $urandom_range(1, 6);
                else            len = $urandom_range(240, 270);
            end else begin
                len = $urandom_range(1, 15);
            end
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 7) == 0)
                    d = r_ref + $urandom_range(0, 2 * r_hyst) - r_hyst;
                else if (seg % 2 == 0)
                    d = r_ref + r_hyst + 1 + $urandom_range(0, 100);
                else
                    d = r_ref - r_hyst - 1 - $urandom_range(0, 100);
                en = ($urandom_range(0, 9) != 0);
                data_in = 16'(d);
                enable  = en;
                model_cycle(d, en);
                step();
            end
        end
        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            data_in = 16'(r_ref - r_hyst - 50);
            model_cycle(r_ref - r_hyst - 50, 1'b1);
            step();
        end
        check("random_event_count", dut_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++)
            check($sformatf("random_event%0d", i), 64'(dut_q[i]), 64'(exp_q[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
